// File: rtl/dig_pkg.sv
// Shared types and constants for the period reader.
// The state enum is shared so the bench and any sibling blocks decode states identically.
package dig_pkg;

  localparam int B_W = 5;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } rd_state_t;

endpackage

// File: rtl/period_capture.sv
// Turns the counter block's b/dig_reset pair into one period sample per reset rising edge.
// The 5-bit count is extended across wrap-arounds; too many wraps saturate the sample.
module period_capture
  import dig_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [B_W-1:0] b,
  input  logic           dig_reset,
  output logic           cap_stb,
  output logic [W-1:0]   sample,
  output logic           sample_sat
);

  localparam int EW = W - B_W;

  logic [B_W-1:0] b_q, b_d;
  logic           dr_q, dr_d;
  logic [EW-1:0]  ext_q, ext_d;
  logic           ssat_q, ssat_d;
  logic           wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q    <= '0;
      dr_q   <= 1'b0;
      ext_q  <= '0;
      ssat_q <= 1'b0;
    end else begin
      b_q    <= b_d;
      dr_q   <= dr_d;
      ext_q  <= ext_d;
      ssat_q <= ssat_d;
    end
  end

  // A zero forced by dig_reset is the counter being held, not a wrap.
  assign wrap    = (b_q == {B_W{1'b1}}) & (b == '0) & ~dig_reset;
  assign cap_stb = dig_reset & ~dr_q;

  always_comb begin
    b_d    = b;
    dr_d   = dig_reset;
    ext_d  = ext_q;
    ssat_d = ssat_q;
    if (cap_stb | ~en) begin
      ext_d  = '0;
      ssat_d = 1'b0;
    end else if (wrap) begin
      if (&ext_q) ssat_d = 1'b1;
      else        ext_d  = ext_q + EW'(1);
    end
  end

  assign sample     = ssat_q ? {W{1'b1}} : {ext_q, b_q};
  assign sample_sat = ssat_q;

endmodule

// File: rtl/dig_period_rd.sv
// Period reader top: sync FSM, N-sample averaging accumulator and a one-deep
// valid/ready output register with sticky overrun.
module dig_period_rd
  import dig_pkg::*;
#(
  parameter int W     = 8,
  parameter int LOG2N = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [B_W-1:0] b,
  input  logic           dig_reset,
  output logic [W-1:0]   avg,
  output logic           avg_valid,
  input  logic           avg_ready,
  output logic           sat,
  output logic           overrun
);

  localparam int AW = W + LOG2N;

  logic           cap_stb, sample_sat;
  logic [W-1:0]   sample;

  rd_state_t      state_q, state_d;
  logic           run;
  logic [AW-1:0]  acc_q, acc_d, acc_sum;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic           sacc_q, sacc_d;
  logic [W-1:0]   avg_q, avg_d;
  logic           valid_q, valid_d;
  logic           sat_q, sat_d;
  logic           ovr_q, ovr_d;
  logic           last, done, take;

  period_capture #(.W(W)) u_cap (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .b          (b),
    .dig_reset  (dig_reset),
    .cap_stb    (cap_stb),
    .sample     (sample),
    .sample_sat (sample_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SYNC;
      acc_q   <= '0;
      cnt_q   <= '0;
      sacc_q  <= 1'b0;
      avg_q   <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sacc_q  <= sacc_d;
      avg_q   <= avg_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
      ovr_q   <= ovr_d;
    end
  end

  // The first capture after sync only marks a period start; the period before it is partial.
  always_comb begin
    state_d = state_q;
    if (!en) state_d = SYNC;
    else begin
      case (state_q)
        SYNC:    if (cap_stb) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = SYNC;
      endcase
    end
  end

  always_comb begin
    run = (state_q == RUN);
  end

  assign acc_sum = acc_q + AW'(sample);
  assign last    = (cnt_q == {LOG2N{1'b1}});
  assign done    = run & en & cap_stb & last;
  assign take    = valid_q & avg_ready;

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    sacc_d = sacc_q;
    if (!en) begin
      acc_d  = '0;
      cnt_d  = '0;
      sacc_d = 1'b0;
    end else if (run && cap_stb) begin
      if (last) begin
        acc_d  = '0;
        cnt_d  = '0;
        sacc_d = 1'b0;
      end else begin
        acc_d  = acc_sum;
        cnt_d  = cnt_q + LOG2N'(1);
        sacc_d = sacc_q | sample_sat;
      end
    end
  end

  // A result arriving on the acceptance cycle replaces the taken one without overrun.
  always_comb begin
    avg_d   = avg_q;
    valid_d = valid_q;
    sat_d   = sat_q;
    ovr_d   = ovr_q;
    if (done) begin
      if (!valid_q || take) begin
        avg_d   = acc_sum[AW-1:LOG2N];
        sat_d   = sacc_q | sample_sat;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (take) begin
      valid_d = 1'b0;
    end
    if (!en) ovr_d = 1'b0;
  end

  assign avg       = avg_q;
  assign avg_valid = valid_q;
  assign sat       = sat_q;
  assign overrun   = ovr_q;

endmodule
